// File: rtl/knn_sdram_arbiter.sv
// knn_sdram_arbiter: shares the single KNN SDRAM master port between the
// loader (port 0) and the distance engine (port 1). One single-word command
// is outstanding at a time; ownership alternates round-robin unless the
// previous owner asked to keep it via its lock input.
module knn_sdram_arbiter #(
  parameter int W      = 16,
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [W-1:0]      r0_wdata,
  output logic              r0_ack,
  output logic [W-1:0]      r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [W-1:0]      r1_wdata,
  output logic              r1_ack,
  output logic [W-1:0]      r1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [W-1:0]      mem_writedata,
  input  logic [W-1:0]      mem_readdata,
  input  logic              mem_waitrequest,
  input  logic              mem_readdatavalid,
  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  state_t            state;
  logic              last_owner;
  logic              lock_hold;
  logic              cmd_we;
  logic [1:0]        req;

  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [W-1:0]      sel_wdata;

  assign req  = {r1_req, r0_req};
  assign busy = (state != IDLE);

  // Owner selection for the next IDLE decision, plus that owner's command fields.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pick = ~last_owner;
    if (lock_hold && req[last_owner]) begin
      pick = last_owner;
    end else if (req == 2'b01) begin
      pick = 1'b0;
    end else if (req == 2'b10) begin
      pick = 1'b1;
    end
    sel_we    = pick ? r1_we    : r0_we;
    sel_addr  = pick ? r1_addr  : r0_addr;
    sel_wdata = pick ? r1_wdata : r0_wdata;
  end

  // Transaction FSM with registered command, ack and read-data outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_owner    <= 1'b1;   // port 0 wins the first contention
      lock_hold     <= 1'b0;
      cmd_we        <= 1'b0;
      grant         <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      r0_ack        <= 1'b0;
      r1_ack        <= 1'b0;
      r0_rdata      <= '0;
      r1_rdata      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      case (state)
        IDLE: begin
          // A lock only survives while its holder keeps requesting.
          if (!req[last_owner]) lock_hold <= 1'b0;
          if (req != 2'b00) begin
            grant         <= pick;
            cmd_we        <= sel_we;
            mem_write     <= sel_we;
            mem_read      <= ~sel_we;
            mem_address   <= sel_addr;
            mem_writedata <= sel_wdata;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          // Command stays untouched while the controller stalls.
          if (!mem_waitrequest) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (cmd_we) begin
              r0_ack <= ~grant;
              r1_ack <= grant;
              state  <= DONE;
            end else begin
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (mem_readdatavalid) begin
            if (grant) r1_rdata <= mem_readdata;
            else       r0_rdata <= mem_readdata;
            r0_ack <= ~grant;
            r1_ack <= grant;
            state  <= DONE;
          end
        end
        DONE: begin
          last_owner <= grant;
          lock_hold  <= grant ? r1_lock : r0_lock;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_sdram_arbiter.sv
// tb_knn_sdram_arbiter: directed and randomized checks of knn_sdram_arbiter.
// The bench plays both requesters and the SDRAM controller, and predicts
// ownership and read data from a transaction-level model of the arbiter.
module tb_knn_sdram_arbiter;
  localparam int W      = 16;
  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [W-1:0]      r0_wdata, r1_wdata;
  logic              r0_ack, r1_ack;
  logic [W-1:0]      r0_rdata, r1_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [W-1:0]      mem_writedata, mem_readdata;
  logic              mem_waitrequest, mem_readdatavalid;
  logic              grant, busy;

  always #5 clk = ~clk;

  knn_sdram_arbiter #(.W(W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
    .grant(grant), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  // SDRAM model state
  logic [W-1:0] smem [64];
  bit           in_cmd, cmd_is_wr, stray, rand_slave;
  int           stall_knob, stall_left, rd_lat, rd_cnt, cmd_cycles;
  logic [ADDR_W-1:0] cmd_addr;
  logic [W-1:0] cmd_data;
  logic [5:0]   rd_idx;

  // Requester state
  bit           req_v [2], lock_v [2], t_we [2];
  logic [ADDR_W-1:0] t_addr [2];
  logic [W-1:0] t_data [2];
  int           remaining [2], gap [2], req_cyc [2], acks [2];
  bit           rand_txn, chk_lat;
  int           lock_mode, exp_lat, cyc;

  // Reference model state
  logic [W-1:0] ref_mem [64];
  logic [W-1:0] exp_rdata [2];
  bit           m_last, m_lock;
  int           inflight;
  int           order [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    r0_req = req_v[0]; r0_we = t_we[0]; r0_lock = lock_v[0];
    r0_addr = t_addr[0]; r0_wdata = t_data[0];
    r1_req = req_v[1]; r1_we = t_we[1]; r1_lock = lock_v[1];
    r1_addr = t_addr[1]; r1_wdata = t_data[1];
  endtask

  task automatic new_txn(input int p);
    if (rand_txn) begin
      t_we[p]   = 1'($urandom_range(0, 1));
      t_addr[p] = ADDR_W'($urandom_range(0, 63));
      t_data[p] = W'($urandom);
    end
  endtask

  task automatic raise(input int p);
    new_txn(p);
    req_v[p]   = 1'b1;
    req_cyc[p] = cyc;
  endtask

  // Requester reaction to its own ack: keep requesting or go quiet.
  task automatic next_txn(input int p);
    if (remaining[p] > 0 && (!rand_txn || $urandom_range(0, 1) == 1)) begin
      new_txn(p);
      req_cyc[p] = cyc;
    end else begin
      req_v[p] = 1'b0;
      gap[p]   = 2 + $urandom_range(0, 3);
    end
    case (lock_mode)
      0:       lock_v[p] = 1'b0;
      1:       lock_v[p] = (p == 0) && (acks[0] < 4);
      default: lock_v[p] = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Predict the owner of a freshly issued command from the requests at the decision edge.
  task automatic model_decide();
    logic [1:0] pend;
    int w;
    pend = {r1_req, r0_req};
    if (m_lock && pend[m_last]) w = m_last ? 1 : 0;
    else if (pend == 2'b01)     w = 0;
    else if (pend == 2'b10)     w = 1;
    else                        w = m_last ? 0 : 1;
    check("grant", 32'(grant), 32'(w));
    check("issue_addr", 32'(mem_address), 32'(t_addr[w]));
    check("issue_write", 32'(mem_write), 32'(t_we[w]));
    check("issue_read", 32'(mem_read), 32'(!t_we[w]));
    if (t_we[w]) check("issue_wdata", 32'(mem_writedata), 32'(t_data[w]));
    inflight = w;
  endtask

  // One clock: observe just after the edge, react, drive inputs for the next edge.
  task automatic tick();
    int  p;
    bit  acked [2];
    @(posedge clk);
    #1;
    cyc++;
    acked[0] = 1'b0;
    acked[1] = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      mem_readdatavalid = (rd_cnt == 0);
      mem_readdata      = (rd_cnt == 0) ? smem[rd_idx] : W'($urandom);
    end else begin
      mem_readdatavalid = stray;
      mem_readdata      = W'($urandom);
    end
    if (mem_read || mem_write) begin
      check("cmd_exclusive", 32'(mem_read & mem_write), 32'(0));
      if (!in_cmd) begin
        in_cmd     = 1'b1;
        cmd_cycles = 0;
        cmd_addr   = mem_address;
        cmd_data   = mem_writedata;
        cmd_is_wr  = mem_write;
        if (rand_slave) stall_knob = $urandom_range(0, 2);
        stall_left = stall_knob;
        model_decide();
      end else begin
        check("hold_addr", 32'(mem_address), 32'(cmd_addr));
        check("hold_wdata", 32'(mem_writedata), 32'(cmd_data));
        check("hold_write", 32'(mem_write), 32'(cmd_is_wr));
      end
      cmd_cycles++;
      if (stall_left > 0) begin
        mem_waitrequest = 1'b1;
        stall_left--;
      end else begin
        mem_waitrequest = 1'b0;
        in_cmd = 1'b0;
        check("cmd_cycles", 32'(cmd_cycles), 32'(stall_knob + 1));
        if (cmd_is_wr) smem[cmd_addr[5:0]] = cmd_data;
        else begin
          if (rand_slave) rd_lat = $urandom_range(1, 3);
          rd_cnt = rd_lat;
          rd_idx = cmd_addr[5:0];
        end
      end
    end else begin
      mem_waitrequest = 1'b0;
    end
    if (r0_ack || r1_ack) begin
      check("ack_exclusive", 32'(r0_ack & r1_ack), 32'(0));
      p = r1_ack ? 1 : 0;
      acked[p] = 1'b1;
      check("ack_owner", 32'(p), 32'(inflight));
      if (t_we[p]) ref_mem[t_addr[p][5:0]] = t_data[p];
      else         exp_rdata[p] = ref_mem[t_addr[p][5:0]];
      check("r0_rdata", 32'(r0_rdata), 32'(exp_rdata[0]));
      check("r1_rdata", 32'(r1_rdata), 32'(exp_rdata[1]));
      if (chk_lat) check("ack_latency", 32'(cyc - req_cyc[p]), 32'(exp_lat));
      acks[p]++;
      order.push_back(p);
      inflight = -1;
      remaining[p]--;
      next_txn(p);
      m_last = (p == 1);
      m_lock = lock_v[p] && req_v[p];
    end
    for (int q = 0; q < 2; q++) begin
      if (!acked[q] && !req_v[q] && remaining[q] > 0) begin
        if (gap[q] > 0) gap[q]--;
        if (gap[q] == 0) raise(q);
      end
    end
    drive();
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((remaining[0] > 0 || remaining[1] > 0) && n < budget) begin
      tick();
      n++;
    end
    check("drained", 32'(remaining[0] + remaining[1]), 32'(0));
    tick();
    tick();
  endtask

  task automatic bench_reset();
    for (int q = 0; q < 2; q++) begin
      req_v[q] = 1'b0; lock_v[q] = 1'b0; t_we[q] = 1'b0;
      t_addr[q] = '0; t_data[q] = '0; remaining[q] = 0; gap[q] = 0;
      req_cyc[q] = 0; acks[q] = 0; exp_rdata[q] = '0;
    end
    in_cmd = 1'b0; rd_cnt = 0; stall_left = 0; stall_knob = 0; rd_lat = 1;
    m_last = 1'b1; m_lock = 1'b0; inflight = -1;
    mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
    drive();
  endtask

  initial begin
    cyc = 0; stray = 1'b0; rand_slave = 1'b0; rand_txn = 1'b0;
    chk_lat = 1'b0; lock_mode = 0; exp_lat = 0;
    for (int i = 0; i < 64; i++) begin
      smem[i]    = W'($urandom);
      ref_mem[i] = smem[i];
    end
    rst = 1'b1;
    bench_reset();
    #12;
    // Reset state
    check("rst_mem_read", 32'(mem_read), 32'(0));
    check("rst_mem_write", 32'(mem_write), 32'(0));
    check("rst_mem_address", 32'(mem_address), 32'(0));
    check("rst_mem_wdata", 32'(mem_writedata), 32'(0));
    check("rst_acks", 32'({r1_ack, r0_ack}), 32'(0));
    check("rst_rdata", 32'({r1_rdata, r0_rdata}), 32'(0));
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Contention straight after reset: strict alternation starting with port 0
    t_we[0] = 1'b1; t_addr[0] = 25'h1; t_data[0] = 16'h1111;
    t_we[1] = 1'b1; t_addr[1] = 25'h2; t_data[1] = 16'h2222;
    remaining[0] = 2; remaining[1] = 2;
    raise(0); raise(1); drive();
    run(100);
    check("rr_len", 32'(order.size()), 32'(4));
    for (int i = 0; i < 4; i++) check("rr_order", 32'(order[i]), 32'(i % 2));

    // Single write on port 0, no stall
    chk_lat = 1'b1; exp_lat = 2;
    t_we[0] = 1'b1; t_addr[0] = 25'h10; t_data[0] = 16'h00AB;
    remaining[0] = 1; raise(0); drive();
    run(50);
    check("wr_mem_0x10", 32'(smem[16]), 32'(16'h00AB));

    // Single read on port 1, data valid 3 cycles after acceptance
    rd_lat = 3; exp_lat = 5;
    t_we[1] = 1'b0; t_addr[1] = 25'h10;
    remaining[1] = 1; raise(1); drive();
    run(50);
    check("rd_r1_rdata", 32'(r1_rdata), 32'(16'h00AB));
    check("rd_r0_kept", 32'(r0_rdata), 32'(exp_rdata[0]));

    // Stray readdatavalid while idle must not touch read data
    stray = 1'b1;
    tick(); tick(); tick();
    stray = 1'b0;
    tick();
    check("stray_r0", 32'(r0_rdata), 32'(exp_rdata[0]));
    check("stray_r1", 32'(r1_rdata), 32'(16'h00AB));
    check("stray_busy", 32'(busy), 32'(0));

    // Write stalled for 8 cycles (port 1, leaving port 1 as last owner)
    stall_knob = 8; exp_lat = 10;
    t_we[1] = 1'b1; t_addr[1] = 25'h22; t_data[1] = 16'h5A5A;
    remaining[1] = 1; raise(1); drive();
    run(50);
    check("stall_mem", 32'(smem[34]), 32'(16'h5A5A));
    stall_knob = 0; chk_lat = 1'b0;

    // Port 0 lock for 4 back-to-back writes while port 1 waits
    order.delete();
    acks[0] = 0; acks[1] = 0; lock_mode = 1;
    t_we[0] = 1'b1; t_addr[0] = 25'h5; t_data[0] = 16'h0505;
    t_we[1] = 1'b1; t_addr[1] = 25'h6; t_data[1] = 16'h0606;
    remaining[0] = 5; remaining[1] = 1; lock_v[0] = 1'b1;
    raise(0); raise(1); drive();
    run(200);
    check("lock_len", 32'(order.size()), 32'(6));
    for (int i = 0; i < 6; i++) check("lock_order", 32'(order[i]), 32'((i == 4) ? 1 : 0));
    lock_mode = 0;

    // Reset in the middle of a read wait
    rd_lat = 10;
    t_we[1] = 1'b0; t_addr[1] = 25'h10;
    remaining[1] = 1; raise(1); drive();
    tick(); tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_cmd", 32'({mem_read, mem_write}), 32'(0));
    check("mid_rst_address", 32'(mem_address), 32'(0));
    check("mid_rst_wdata", 32'(mem_writedata), 32'(0));
    check("mid_rst_acks", 32'({r1_ack, r0_ack}), 32'(0));
    check("mid_rst_rdata", 32'({r1_rdata, r0_rdata}), 32'(0));
    check("mid_rst_grant_busy", 32'({grant, busy}), 32'(0));
    bench_reset();
    tick(); tick();
    rst = 1'b0;
    order.delete();
    t_we[0] = 1'b1; t_addr[0] = 25'h3; t_data[0] = 16'h3333;
    t_we[1] = 1'b0; t_addr[1] = 25'h3;
    remaining[0] = 1; remaining[1] = 1;
    raise(0); raise(1); drive();
    run(100);
    check("post_rst_len", 32'(order.size()), 32'(2));
    check("post_rst_first", 32'(order[0]), 32'(0));
    check("post_rst_rdata", 32'(r1_rdata), 32'(16'h3333));

    // Randomized traffic against the model
    rand_txn = 1'b1; rand_slave = 1'b1; lock_mode = 2;
    acks[0] = 0; acks[1] = 0;
    remaining[0] = 25; remaining[1] = 25;
    raise(0); raise(1); drive();
    run(5000);
    check("rand_acks0", 32'(acks[0]), 32'(25));
    check("rand_acks1", 32'(acks[1]), 32'(25));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
